clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised multi-channel clock/tick generator running from the 50 MHz board clock. Each channel divides `clk_50mhz` by a runtime-programmable half-period and produces either a square wave or a one-cycle strobe. It is the successor to the team's fixed single-output divider and feeds display scanning, debouncers and LED blink logic. Divisors are loaded through a valid/ready configuration port; channels can be gated individually and phase-aligned together.

## Interface
- `N_CH`, default 4: number of independent divider channels (1..16).
- `CNT_W`, default 25: counter and half-period width in bits.
- `DEF_HALF`, default 2_083_332: per-channel half-period loaded at reset (12 Hz square wave).
- `clk_50mhz`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  N_CH  per-channel count enable.
- `sync`  in  1  one-cycle request to restart all channels in phase.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  configuration port can accept.
- `cfg_ch`  in  max(1,$clog2(N_CH))  target channel index.
- `cfg_half`  in  CNT_W  new half-period value H.
- `cfg_mode`  in  1  0 = square, 1 = pulse.
- `cfg_err`  out  1  one-cycle flag: accepted request had `cfg_ch >= N_CH`.
- `clk_out`  out  N_CH  divided outputs.
- `tick`  out  N_CH  one-cycle strobe at each terminal count.

## Operation
- Reset (`rst`=0): all counters 0, `clk_out`=0, `tick`=0, `cfg_err`=0, `cfg_ready`=0, half = `DEF_HALF`, mode = square.
- `cfg_ready` rises on the first `clk_50mhz` edge after reset release.
- Per channel, on each edge with `en[i]`=1: if counter == H, the counter goes to 0, `tick[i]` is asserted for that cycle, and in square mode `clk_out[i]` toggles. Otherwise the counter increments.
- Square mode: output period 2·(H+1) cycles, 50 % duty. Pulse mode: `clk_out[i]` equals `tick[i]`, period H+1.
- H = 0: square mode toggles every cycle; pulse mode gives a continuous high.
- `en[i]`=0: counter and `clk_out[i]` hold their values; `tick[i]`=0.
- `sync`=1: every counter clears to 0 and `clk_out` clears to 0 on that edge. Priority is reset > sync > count, and sync applies regardless of `en`.
- Config transfer occurs when `cfg_valid && cfg_ready` on an edge.
  - An out-of-range `cfg_ch` is dropped and `cfg_err` pulses on the next cycle.
- Immediate update (macro off): H and mode are written on the transfer edge.
  - If the current counter is ≥ the new H, the counter restarts at 0 and the output level is kept. This prevents a 2^CNT_W wrap.
  - Mode change to pulse forces `clk_out[i]`=0.
- A transfer in the same cycle as `sync` takes effect, and the sync restart still applies.
- Counter arithmetic is unsigned CNT_W. The counter never exceeds H.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- After reset release with `en`=1: the first toggle/tick occurs on the (H+1)th rising edge.
- Config write is visible to the compare logic on the edge after the transfer.
- `sync` takes effect on its edge. The next tick follows H+1 edges later.
- `cfg_ready` is always 1 after reset when the macro is off.

## Configuration
- `CLK_DIV_SHADOW_EN` defined: the transfer writes a per-channel shadow register plus a pending flag. The shadow is copied to active H/mode at that channel's next terminal count, or immediately on `sync`. This gives glitch-free period changes.
  - `cfg_ready` is 0 while the addressed `cfg_ch` has an update pending; valid must be held.
  - With `en[i]`=0 the pending update waits until counting resumes or `sync` arrives.
- Undefined: immediate-update behaviour as in Operation; no shadow registers.

## Structure
- Package `clk_div_pkg`: `CNT_W` default, `DEF_HALF`, mode enum (`MODE_SQUARE`, `MODE_PULSE`), clock-frequency constant 50_000_000, and a `half_for_hz(f)` function returning 50e6/(2f)−1.
- Sub-module `clk_div_ch`: one channel (counter, H/mode registers, optional shadow), generated N_CH times. The top holds cfg decode, `cfg_ready`/`cfg_err` and `sync` fan-out.

## Test plan
- Reset, `en`=1 on ch0, load H=3 square on ch0 → `clk_out[0]` toggles every 4 cycles (period 8); `tick[0]` pulses every 4 cycles.
- Load H=4 pulse on ch1 → `clk_out[1]` is high one cycle in every 5; `en[1]`=0 for 7 cycles → output frozen and no ticks, then resumes with the counter where it stopped.
- ch0 at H=9 with counter at 7, write H=5 → macro off: counter restarts at 0. Macro on: `cfg_ready` low until the terminal count at 9, then the period becomes 6 half-cycles.
- ch0 H=3, ch2 H=7, pulse `sync` → both `clk_out`=0 on the next edge, and ticks align at cycle 4 (ch0) and cycle 8 (both).
- Write with `cfg_ch`=5 (N_CH=4) → `cfg_err` pulses once; no channel changes.
- Assert `rst` mid-period → all outputs 0 immediately and H returns to `DEF_HALF`. After release, `cfg_ready`=1 on the first edge.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants, channel mode type and frequency helper for the clk_div_bank divider family.
package clk_div_pkg;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned CNT_W_DEFAULT = 25;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  // Half-period that yields a square wave of f Hz from the board clock.
  function automatic int unsigned half_for_hz(input int unsigned f);
    return (CLK_HZ / (2 * f)) - 1;
  endfunction

  localparam int unsigned DEF_HALF_DEFAULT = half_for_hz(12);

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active half-period/mode and, with CLK_DIV_SHADOW_EN defined,
// a shadow half-period/mode applied at the next terminal count or on sync.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W    = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_DEFAULT)
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_half_i,
  input  logic             wr_mode_i,
`ifdef CLK_DIV_SHADOW_EN
  output logic             pend_o,
`endif
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  mode_e            mode_q, mode_d;
  mode_e            wr_mode;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             terminal;

`ifdef CLK_DIV_SHADOW_EN
  logic [CNT_W-1:0] sh_half_q, sh_half_d;
  mode_e            sh_mode_q, sh_mode_d;
  logic             pend_q, pend_d;
  assign pend_o = pend_q;
`endif

  assign wr_mode  = mode_e'(wr_mode_i);
  assign terminal = en_i && (cnt_q == half_q);

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    mode_d = mode_q;
    out_d  = out_q;
    tick_d = 1'b0;
`ifdef CLK_DIV_SHADOW_EN
    sh_half_d = sh_half_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
`endif

    if (terminal) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      out_d  = (mode_q == MODE_SQUARE) ? ~out_q : 1'b1;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
      if (mode_q == MODE_PULSE) out_d = 1'b0;
    end

`ifdef CLK_DIV_SHADOW_EN
    if (wr_i) begin
      sh_half_d = wr_half_i;
      sh_mode_d = wr_mode;
      pend_d    = 1'b1;
    end else if (pend_q && terminal) begin
      half_d = sh_half_q;
      mode_d = sh_mode_q;
      pend_d = 1'b0;
    end
`else
    if (wr_i) begin
      half_d = wr_half_i;
      mode_d = wr_mode;
      // Shrinking below the current count would otherwise run the counter through a full wrap.
      if (cnt_q >= wr_half_i) begin
        cnt_d  = '0;
        tick_d = 1'b0;
        out_d  = out_q;
      end
    end
`endif

    if (mode_q == MODE_SQUARE && mode_d == MODE_PULSE) out_d = 1'b0;

    if (sync_i) begin
      cnt_d  = '0;
      out_d  = 1'b0;
      tick_d = 1'b0;
`ifdef CLK_DIV_SHADOW_EN
      if (wr_i) begin
        half_d = wr_half_i;
        mode_d = wr_mode;
      end else if (pend_q) begin
        half_d = sh_half_q;
        mode_d = sh_mode_q;
      end
      pend_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      half_q    <= DEF_HALF;
      mode_q    <= MODE_SQUARE;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
`ifdef CLK_DIV_SHADOW_EN
      sh_half_q <= DEF_HALF;
      sh_mode_q <= MODE_SQUARE;
      pend_q    <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
`ifdef CLK_DIV_SHADOW_EN
      sh_half_q <= sh_half_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
`endif
    end
  end

  assign clk_out_o = out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel clock/tick divider: config decode, cfg_ready/cfg_err and sync fan-out.
// Define CLK_DIV_SHADOW_EN for shadowed (terminal-count aligned) period updates.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned      N_CH     = 4,
  parameter int unsigned      CNT_W    = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_DEFAULT),
  localparam int unsigned     CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_mode,
  output logic             cfg_err,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic            ready_q;
  logic            err_q, err_d;
  logic            in_range;
  logic            xfer;
  logic [N_CH-1:0] wr;

  assign in_range = (32'(cfg_ch) < N_CH);

`ifdef CLK_DIV_SHADOW_EN
  localparam int unsigned CH_N = 1 << CH_W;
  logic [N_CH-1:0] pend;
  logic [CH_N-1:0] pend_ext;
  // Zero-extended so an out-of-range index reads as "nothing pending".
  assign pend_ext  = CH_N'(pend);
  assign cfg_ready = ready_q & ~pend_ext[cfg_ch];
`else
  assign cfg_ready = ready_q;
`endif

  assign xfer  = cfg_valid & cfg_ready;
  assign err_d = xfer & ~in_range;

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= err_d;
    end
  end

  assign cfg_err = err_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr[i] = xfer && in_range && (cfg_ch == CH_W'(i));

    clk_div_ch #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .en_i      (en[i]),
      .sync_i    (sync),
      .wr_i      (wr[i]),
      .wr_half_i (cfg_half),
      .wr_mode_i (cfg_mode),
`ifdef CLK_DIV_SHADOW_EN
      .pend_o    (pend[i]),
`endif
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank (3 channels, small reset half-period) in the default build.
module tb_clk_div_bank;

  localparam int unsigned DEFH = 20;

  logic        clk_50mhz = 1'b0;
  logic        rst;
  logic [2:0]  en;
  logic        sync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [24:0] cfg_half;
  logic        cfg_mode;
  logic        cfg_err;
  logic [2:0]  clk_out;
  logic [2:0]  tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] en;
    logic [2:0] mask;
    logic [2:0] tk;
    logic [2:0] co;
    logic       err;
    logic       rdy;
  } exp_t;

  exp_t win[$];
  exp_t sbq[$];

  clk_div_bank #(
    .N_CH     (3),
    .CNT_W    (25),
    .DEF_HALF (25'(DEFH))
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic open_window(input int unsigned n, input logic [2:0] en_v);
    exp_t e;
    win.delete();
    e.en = en_v; e.mask = '0; e.tk = '0; e.co = '0; e.err = 1'b0; e.rdy = 1'b1;
    repeat (n) win.push_back(e);
  endtask

  task automatic set_en(input int unsigned off, input int unsigned n, input logic [2:0] en_v);
    exp_t e;
    for (int unsigned k = 0; k < n; k++) begin
      e = win[off+k]; e.en = en_v; win[off+k] = e;
    end
  endtask

  // Expected waveform from "el" edges elapsed since the counter was 0 with output o0.
  task automatic add_wave(input int unsigned ch, input int unsigned off, input int unsigned n,
                          input int unsigned h, input bit pulse, input int unsigned el, input bit o0);
    exp_t e;
    int unsigned t;
    bit tk, co;
    for (int unsigned k = 1; k <= n; k++) begin
      t  = k + el;
      tk = ((t % (h + 1)) == 0);
      co = pulse ? tk : (o0 ^ (((t / (h + 1)) % 2) == 1));
      e = win[off+k-1];
      e.mask[ch] = 1'b1; e.tk[ch] = tk; e.co[ch] = co;
      win[off+k-1] = e;
    end
  endtask

  task automatic add_hold(input int unsigned ch, input int unsigned off, input int unsigned n, input bit co);
    exp_t e;
    for (int unsigned k = 0; k < n; k++) begin
      e = win[off+k];
      e.mask[ch] = 1'b1; e.tk[ch] = 1'b0; e.co[ch] = co;
      win[off+k] = e;
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input int unsigned h, input logic m, input logic s);
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL cfg_ready_before_write actual=%b required=1", cfg_ready);
    end
    cfg_valid = 1'b1; cfg_ch = ch; cfg_half = 25'(h); cfg_mode = m; sync = s;
  endtask

  task automatic drain(input string name);
    exp_t e;
    int unsigned idx;
    foreach (win[i]) sbq.push_back(win[i]);
    win.delete();
    idx = 0;
    while (sbq.size() > 0) begin
      e  = sbq.pop_front();
      en = e.en;
      step();
      cfg_valid = 1'b0;
      sync      = 1'b0;
      idx++;
      if (e.mask != 3'b000) begin
        total++;
        if ((tick & e.mask) !== (e.tk & e.mask)) begin
          bad++;
          $display("FAIL %s_tick cycle=%0d actual=%b required=%b mask=%b", name, idx, tick, e.tk, e.mask);
        end
        total++;
        if ((clk_out & e.mask) !== (e.co & e.mask)) begin
          bad++;
          $display("FAIL %s_clk_out cycle=%0d actual=%b required=%b mask=%b", name, idx, clk_out, e.co, e.mask);
        end
      end
      total++;
      if (cfg_err !== e.err) begin
        bad++;
        $display("FAIL %s_cfg_err cycle=%0d actual=%b required=%b", name, idx, cfg_err, e.err);
      end
      total++;
      if (cfg_ready !== e.rdy) begin
        bad++;
        $display("FAIL %s_cfg_ready cycle=%0d actual=%b required=%b", name, idx, cfg_ready, e.rdy);
      end
    end
  endtask

  task automatic check_quiet(input string name);
    total++;
    if (clk_out !== 3'b000 || tick !== 3'b000) begin
      bad++;
      $display("FAIL %s_outputs actual clk_out=%b tick=%b required 000/000", name, clk_out, tick);
    end
    total++;
    if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL %s_cfg actual ready=%b err=%b required 0/0", name, cfg_ready, cfg_err);
    end
  endtask

  task automatic test_reset();
    #5;
    check_quiet("reset");
    step();
    check_quiet("reset_held");
    rst = 1'b1;
    open_window(21, 3'b001);
    add_wave(0, 0, 21, DEFH, 1'b0, 0, 1'b0);
    add_hold(1, 0, 21, 1'b0);
    add_hold(2, 0, 21, 1'b0);
    drain("reset_release");
  endtask

  task automatic test_square();
    cfg_write(2'd0, 3, 1'b0, 1'b1);
    open_window(17, 3'b001);
    add_hold(0, 0, 1, 1'b0);
    add_wave(0, 1, 16, 3, 1'b0, 0, 1'b0);
    add_hold(1, 0, 17, 1'b0);
    add_hold(2, 0, 17, 1'b0);
    drain("square");
  endtask

  task automatic test_pulse_gate();
    cfg_write(2'd1, 4, 1'b1, 1'b1);
    open_window(13, 3'b011);
    add_hold(0, 0, 1, 1'b0);
    add_hold(1, 0, 1, 1'b0);
    add_wave(0, 1, 12, 3, 1'b0, 0, 1'b0);
    add_wave(1, 1, 12, 4, 1'b1, 0, 1'b0);
    add_hold(2, 0, 13, 1'b0);
    drain("pulse");
    open_window(7, 3'b001);
    add_wave(0, 0, 7, 3, 1'b0, 12, 1'b0);
    add_hold(1, 0, 7, 1'b0);
    drain("gated");
    open_window(10, 3'b011);
    add_wave(0, 0, 10, 3, 1'b0, 19, 1'b0);
    add_wave(1, 0, 10, 4, 1'b1, 12, 1'b0);
    drain("resume");
  endtask

  task automatic test_shrink();
    cfg_write(2'd0, 9, 1'b0, 1'b1);
    open_window(8, 3'b001);
    add_hold(0, 0, 1, 1'b0);
    add_wave(0, 1, 7, 9, 1'b0, 0, 1'b0);
    add_hold(1, 0, 8, 1'b0);
    add_hold(2, 0, 8, 1'b0);
    drain("shrink_setup");
    cfg_write(2'd0, 5, 1'b0, 1'b0);
    open_window(13, 3'b001);
    add_hold(0, 0, 1, 1'b0);
    add_wave(0, 1, 12, 5, 1'b0, 0, 1'b0);
    add_hold(1, 0, 13, 1'b0);
    add_hold(2, 0, 13, 1'b0);
    drain("shrink");
  endtask

  task automatic test_sync();
    cfg_write(2'd2, 7, 1'b0, 1'b0);
    open_window(1, 3'b111);
    drain("sync_pre_a");
    cfg_write(2'd0, 3, 1'b0, 1'b0);
    open_window(6, 3'b111);
    drain("sync_pre_b");
    sync = 1'b1;
    open_window(11, 3'b111);
    set_en(0, 1, 3'b101);
    add_hold(0, 0, 1, 1'b0);
    add_hold(1, 0, 1, 1'b0);
    add_hold(2, 0, 1, 1'b0);
    add_wave(0, 1, 10, 3, 1'b0, 0, 1'b0);
    add_wave(1, 1, 10, 4, 1'b1, 0, 1'b0);
    add_wave(2, 1, 10, 7, 1'b0, 0, 1'b0);
    drain("sync");
  endtask

  task automatic test_cfg_err();
    exp_t e;
    cfg_write(2'd3, 1, 1'b1, 1'b0);
    open_window(4, 3'b111);
    e = win[0]; e.err = 1'b1; win[0] = e;
    add_wave(0, 0, 4, 3, 1'b0, 10, 1'b0);
    add_wave(1, 0, 4, 4, 1'b1, 10, 1'b0);
    add_wave(2, 0, 4, 7, 1'b0, 10, 1'b0);
    drain("cfg_err");
  endtask

  task automatic test_mid_reset();
    #3;
    rst = 1'b0;
    #1;
    check_quiet("mid_reset");
    step();
    check_quiet("mid_reset_held");
    rst = 1'b1;
    open_window(21, 3'b001);
    add_wave(0, 0, 21, DEFH, 1'b0, 0, 1'b0);
    add_hold(1, 0, 21, 1'b0);
    add_hold(2, 0, 21, 1'b0);
    drain("after_reset");
  endtask

  initial begin
    rst = 1'b0; en = 3'b001; sync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_half = '0; cfg_mode = 1'b0;
    test_reset();
    test_square();
    test_pulse_gate();
    test_shrink();
    test_sync();
    test_cfg_err();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
